// File: rtl/fb_plot_if.sv
// Pixel-plot, clear and scan-out signal bundle for fb_plot_sink.
// master drives plots, clear requests and scan ticks; slave is the sink.
interface fb_plot_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       ready;
    logic       clear_req;
    logic       clearing;
    logic       pix_tick;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_colour;
    logic       frame_start;
    logic       overflow;
    logic       oob;

    modport master (
        output plot, x, y, colour, clear_req, pix_tick,
        input  ready, clearing, pix_valid, pix_x, pix_y,
        input  pix_colour, frame_start, overflow, oob
    );

    modport slave (
        input  plot, x, y, colour, clear_req, pix_tick,
        output ready, clearing, pix_valid, pix_x, pix_y,
        output pix_colour, frame_start, overflow, oob
    );
endinterface

// File: rtl/fb_plot_sink.sv
// Plot sink: queues pixel writes in a small FIFO and commits them to a
// single-port framebuffer shared with raster scan-out and a clear sweep.
module fb_plot_sink #(
    parameter int X_PIXELS   = 160,
    parameter int Y_PIXELS   = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    fb_plot_if.slave   bus
);
    localparam int NPIX = X_PIXELS * Y_PIXELS;
    localparam int AW   = 15;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;

    typedef enum logic {
        S_RUN,
        S_CLEAR
    } state_t;

    plot_t         fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [7:0]    rx;
    logic [6:0]    ry;
    logic [2:0]    mem [NPIX];

    logic          in_range;
    logic          push;
    logic          pop;
    logic          clr_we;
    logic          we;
    plot_t         head;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;

    // Row-major address; for 160 columns this is (y<<7)+(y<<5)+x.
    function automatic logic [AW-1:0] addr_of(
        input logic [7:0] col,
        input logic [6:0] row
    );
        return AW'(row) * AW'(X_PIXELS) + AW'(col);
    endfunction

    // Space is judged on the registered count only, so a same-cycle
    // pop never makes room for a push.
    assign bus.ready = (count < CW'(FIFO_DEPTH));
    assign in_range  = (bus.x < 8'(X_PIXELS)) && (bus.y < 7'(Y_PIXELS));
    assign push      = bus.plot && in_range && bus.ready;
    assign head      = fifo_q[rd_ptr];

    // Memory port arbitration: scan tick, then clear, then FIFO drain.
    assign pop     = (state == S_RUN) && !bus.pix_tick && (count != '0);
    assign clr_we  = (state == S_CLEAR) && !bus.pix_tick;
    assign we      = !reset && (clr_we || pop);
    assign rd_addr = addr_of(rx, ry);
    assign wr_addr = clr_we ? clr_ptr : addr_of(head.x, head.y);
    assign wr_data = clr_we ? 3'd0 : head.c;

    // Framebuffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Plot FIFO with sticky drop flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
            bus.oob      <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{x: bus.x, y: bus.y, c: bus.colour};
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0
                                                          : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0
                                                          : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (bus.plot && !in_range) begin
                bus.oob <= 1'b1;
            end
            if (bus.plot && in_range && !bus.ready) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    // Run/clear sequencer; the sweep stalls on cycles taken by a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            clr_ptr      <= '0;
            bus.clearing <= 1'b0;
        end else begin
            unique case (state)
                S_RUN: begin
                    if (bus.clear_req) begin
                        state        <= S_CLEAR;
                        clr_ptr      <= '0;
                        bus.clearing <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (!bus.pix_tick) begin
                        if (clr_ptr == LAST) begin
                            state        <= S_RUN;
                            clr_ptr      <= '0;
                            bus.clearing <= 1'b0;
                        end else begin
                            clr_ptr <= clr_ptr + 1'b1;
                        end
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    // Raster scan-out: one registered pixel per tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx              <= '0;
            ry              <= '0;
            bus.pix_valid   <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.pix_x       <= '0;
            bus.pix_y       <= '0;
            bus.pix_colour  <= '0;
        end else begin
            bus.pix_valid   <= bus.pix_tick;
            bus.frame_start <= bus.pix_tick && (rx == '0) && (ry == '0);
            if (bus.pix_tick) begin
                bus.pix_x      <= rx;
                bus.pix_y      <= ry;
                bus.pix_colour <= mem[rd_addr];
                if (rx == 8'(X_PIXELS - 1)) begin
                    rx <= '0;
                    ry <= (ry == 7'(Y_PIXELS - 1)) ? '0 : ry + 1'b1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_plot_sink.sv
// Bench for fb_plot_sink: directed scenarios plus random plots/ticks,
// every cycle compared against a queue-and-array reference model.
module tb_fb_plot_sink;
    localparam int XP = 160;
    localparam int YP = 120;
    localparam int NP = XP * YP;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_plot_if bus ();

    fb_plot_sink dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } ent_t;

    int n_pass = 0;
    int n_total = 0;

    ent_t       q[$];
    logic [2:0] mm [NP];
    int         rast;
    int         cptr;
    bit         clr_on;
    bit         ovf;
    bit         oobf;
    logic       e_valid;
    logic       e_fs;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: evaluated once per clock on the sampled inputs.
    task automatic model_step();
        bit   was_clr;
        bit   full;
        ent_t e;
        if (reset) begin
            q.delete();
            rast = 0;
            cptr = 0;
            clr_on = 0;
            ovf = 0;
            oobf = 0;
            e_valid = 0;
            e_fs = 0;
            e_x = 0;
            e_y = 0;
            e_c = 0;
            return;
        end
        was_clr = clr_on;
        full = (q.size() >= 4);
        e_valid = 0;
        e_fs = 0;
        if (bus.pix_tick) begin
            e_valid = 1;
            e_x = 8'(rast % XP);
            e_y = 7'(rast / XP);
            e_c = mm[rast];
            e_fs = (rast == 0);
            rast = (rast + 1) % NP;
        end else if (clr_on) begin
            mm[cptr] = 3'd0;
            if (cptr == NP - 1) begin
                clr_on = 0;
                cptr = 0;
            end else begin
                cptr++;
            end
        end else if (q.size() > 0) begin
            e = q.pop_front();
            mm[e.y * XP + e.x] = 3'(e.c);
        end
        if (!was_clr && bus.clear_req) begin
            clr_on = 1;
            cptr = 0;
        end
        if (bus.plot) begin
            if (int'(bus.x) >= XP || int'(bus.y) >= YP) oobf = 1;
            else if (full) ovf = 1;
            else q.push_back('{int'(bus.x), int'(bus.y), int'(bus.colour)});
        end
    endtask

    task automatic cyc();
        logic [23:0] got;
        logic [23:0] want;
        @(posedge clk);
        model_step();
        #1;
        got = {bus.ready, bus.clearing, bus.pix_valid, bus.frame_start,
               bus.overflow, bus.oob, bus.pix_x, bus.pix_y, bus.pix_colour};
        want = {1'(q.size() < 4), clr_on, e_valid, e_fs, ovf, oobf,
                e_x, e_y, e_c};
        check("cycle", 32'(got), 32'(want));
    endtask

    task automatic set_in(input bit p, input int xx, input int yy,
                          input int cc, input bit cr, input bit tk);
        bus.plot = p;
        bus.x = 8'(xx);
        bus.y = 7'(yy);
        bus.colour = 3'(cc);
        bus.clear_req = cr;
        bus.pix_tick = tk;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    // Counts cycles with clearing high right after a clear_req cycle.
    task automatic clear_len(input string tag);
        int cnt;
        cnt = 0;
        set_in(0, 0, 0, 0, 0, 0);
        while (bus.clearing && cnt < 20000) begin
            cnt++;
            cyc();
        end
        check(tag, 32'(cnt), 32'd19200);
    endtask

    initial begin
        int  fs_cnt;
        int  px;
        int  py;
        int  seen;
        bit  p;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_clearing", 32'(bus.clearing), 32'd0);
        check("rst_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_flags", 32'({bus.overflow, bus.oob, bus.frame_start}),
              32'd0);
        check("rst_pix", 32'({bus.pix_x, bus.pix_y, bus.pix_colour}), 32'd0);

        // Initial sweep gives a known all-zero framebuffer.
        set_in(0, 0, 0, 0, 1, 0);
        cyc();
        clear_len("clear_len_init");
        idle(2);

        // Single write, then scan up to raster (5,3).
        set_in(1, 5, 3, 5, 0, 0);
        cyc();
        idle(2);
        for (int i = 0; i < 486; i++) begin
            set_in(0, 0, 0, 0, 0, 1);
            cyc();
        end
        check("t1_x", 32'(bus.pix_x), 32'd5);
        check("t1_y", 32'(bus.pix_y), 32'd3);
        check("t1_colour", 32'(bus.pix_colour), 32'd5);

        // Out-of-range plots are discarded.
        set_in(1, 160, 0, 7, 0, 0);
        cyc();
        set_in(1, 0, 120, 7, 0, 0);
        cyc();
        idle(1);
        check("oob_flag", 32'(bus.oob), 32'd1);
        check("oob_ready", 32'(bus.ready), 32'd1);

        // Overflow while ticks starve the write port.
        for (int i = 0; i < 5; i++) begin
            set_in(1, 100 + i, 3, i + 1, 0, 1);
            cyc();
            if (i == 3) check("ovf_ready_low", 32'(bus.ready), 32'd0);
        end
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        idle(6);
        check("ovf_drained", 32'(bus.ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 110; i++) begin
            set_in(0, 0, 0, 0, 0, 1);
            cyc();
            if (bus.pix_y == 7'd3 && bus.pix_x >= 8'd100
                && bus.pix_x <= 8'd104) begin
                seen++;
                if (bus.pix_x == 8'd104)
                    check("ovf_dropped", 32'(bus.pix_colour), 32'd0);
                else
                    check("ovf_written", 32'(bus.pix_colour),
                          32'(bus.pix_x - 8'd99));
            end
        end
        check("ovf_seen", 32'(seen), 32'd5);
        idle(2);

        // Random plots and ticks.
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 9) < 4);
            set_in(p, $urandom_range(0, 169), $urandom_range(0, 124),
                   $urandom_range(0, 7), 0, 1'($urandom_range(0, 1)));
            cyc();
        end
        idle(8);

        // Fill two rows, then clear with a same-cycle plot.
        for (int i = 0; i < 2 * XP; i++) begin
            set_in(1, i % XP, i / XP, 7, 0, 0);
            cyc();
        end
        set_in(1, 10, 10, 2, 1, 0);
        cyc();
        clear_len("clear_len_fill");
        idle(3);

        // Full frame plus one: contents and raster wrap.
        do_reset();
        fs_cnt = 0;
        px = -1;
        py = -1;
        for (int i = 1; i <= NP + 1; i++) begin
            set_in(0, 0, 0, 0, 0, 1);
            cyc();
            if (bus.frame_start) fs_cnt++;
            if (i == 1) check("fs_first", 32'(bus.frame_start), 32'd1);
            if (i == NP + 1) check("fs_last", 32'(bus.frame_start), 32'd1);
            if (px == 159 && py == 0)
                check("wrap_row", 32'({bus.pix_x, bus.pix_y}),
                      32'({8'd0, 7'd1}));
            if (px == 159 && py == 119)
                check("wrap_frame", 32'({bus.pix_x, bus.pix_y}), 32'd0);
            if (i <= NP && bus.pix_x == 8'd10 && bus.pix_y == 7'd10)
                check("clr_plot_kept", 32'(bus.pix_colour), 32'd2);
            if (i <= NP && bus.pix_y == 7'd0 && bus.pix_x == 8'd0)
                check("clr_zero", 32'(bus.pix_colour), 32'd0);
            px = int'(bus.pix_x);
            py = int'(bus.pix_y);
        end
        check("fs_count", 32'(fs_cnt), 32'd2);
        idle(2);

        // Reset in the middle of a sweep at clear pointer 100.
        for (int i = 0; i < 2 * XP; i++) begin
            set_in(1, i % XP, i / XP, 6, 0, 0);
            cyc();
        end
        idle(2);
        set_in(0, 0, 0, 0, 1, 0);
        cyc();
        idle(100);
        do_reset();
        check("mid_clearing", 32'(bus.clearing), 32'd0);
        check("mid_ready", 32'(bus.ready), 32'd1);
        check("mid_outs", 32'({bus.pix_valid, bus.frame_start, bus.overflow,
              bus.oob, bus.pix_x, bus.pix_y, bus.pix_colour}), 32'd0);
        for (int i = 0; i < 2 * XP; i++) begin
            set_in(0, 0, 0, 0, 0, 1);
            cyc();
            if (i == 99) check("mid_cleared", 32'(bus.pix_colour), 32'd0);
            if (i == 100) check("mid_kept", 32'(bus.pix_colour), 32'd6);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
